fmac_seq: RTL
=============

# fmac_seq

Parameterised floating-point multiply-accumulate sequencer. It computes r = init_val + Σ a_i·b_i over N_TERMS operand pairs that arrive on a valid/ready stream. The block owns no arithmetic: it time-shares one external FloPoCo multiplier and one external FloPoCo adder through ce-gated operand/result ports. Unlike the fixed fmac state chain, it supports arbitrary term counts and core pipeline depths, and it tolerates input and output back-pressure.

## Interface
- WIDTH, 11, FloPoCo word width (2 exception + sign + wE + wF; 11 = wE 4 / wF 4)
- N_TERMS, 4, number of product terms per accumulation (≥1)
- MUL_LAT, 1, multiplier pipeline depth in ce-high cycles (≥1)
- ADD_LAT, 1, adder pipeline depth in ce-high cycles (≥1)
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin accumulation; sampled only in IDLE
- init_val  in  WIDTH  accumulator seed; captured on accepted start
- busy  out  1  high in every state except IDLE
- in_valid / in_ready  in / out  1  operand stream handshake
- in_a, in_b  in  WIDTH  operand pair
- out_valid / out_ready  out / in  1  result handshake
- out_r  out  WIDTH  accumulated result
- fmul_x, fmul_y  out  WIDTH  multiplier operands, registered
- fmul_ce  out  1  multiplier clock enable, registered
- fmul_r  in  WIDTH  multiplier result
- fadd_x, fadd_y  out  WIDTH  adder operands, registered
- fadd_ce  out  1  adder clock enable, registered
- fadd_r  in  WIDTH  adder result

## Operation
- States: IDLE, FETCH, MUL, ADD, DONE.
- Reset value of every output and register is 0, including busy, in_ready, out_valid, both ce lines, all operand ports, and out_r. The FSM resets to IDLE.
- IDLE, on start:
  - acc <= init_val, term counter <= 0.
  - Go to FETCH.
- FETCH:
  - in_ready = 1.
  - On in_valid & in_ready: fmul_x <= in_a, fmul_y <= in_b, fmul_ce <= 1, lat counter <= MUL_LAT.
  - Go to MUL.
- MUL:
  - fmul_ce is held at 1 and fmul_x/fmul_y are held stable; lat counter decrements each cycle.
  - On the edge that ends the MUL_LAT-th ce-high cycle, do all of the following, then go to ADD:
    - sample fmul_r;
    - fmul_ce <= 0;
    - fadd_x <= acc, fadd_y <= fmul_r, fadd_ce <= 1;
    - lat counter <= ADD_LAT.
- ADD:
  - Same scheme as MUL, using ADD_LAT.
  - On the final edge: acc <= fadd_r, fadd_ce <= 0, term counter + 1.
  - If the term counter was N_TERMS-1, go to DONE; otherwise go to FETCH.
- DONE:
  - out_valid = 1, out_r = acc, held stable until out_ready.
  - On the handshake go to IDLE. out_r keeps its value; out_valid drops.
- Operand ports: outside the active MUL/ADD window they hold their last value, and the ce lines are 0. The cores must not advance while ce = 0.
- No arithmetic is performed in this block. NaN, Inf and zero propagate through the cores untouched.

## Timing
- Per term: 1 FETCH cycle (with in_valid already high) + MUL_LAT + ADD_LAT cycles.
- Total latency from start sampled to out_valid high, with no stalls: 1 + N_TERMS·(1 + MUL_LAT + ADD_LAT) cycles.
- Input stall: FETCH waits indefinitely while in_valid = 0. Both ce lines stay 0 and acc is unchanged.
- Output stall: DONE holds indefinitely and in_ready stays 0.
- start while busy is ignored. start together with out_ready in DONE is not accepted; start is accepted only from IDLE on the following cycle.
- N_TERMS = 1: a single FETCH/MUL/ADD pass, then DONE.
- Reset mid-operation: immediate return to IDLE, all outputs 0, the partial accumulation is discarded, and both ce lines drop in the same instant.
- Counter widths:
  - term counter: $clog2(N_TERMS+1);
  - lat counter: $clog2(max(MUL_LAT, ADD_LAT)+1).

## Structure
- Shared package fmac_pkg holds:
  - the state enum fmac_state_t;
  - FloPoCo field-width constants (exception bits = 2);
  - the constants FP_ZERO and FP_ONE as functions of wE/wF.
- No sub-modules are instantiated. The FloPoCo cores live in the parent, which wires them to the fmul_*/fadd_* ports.

## Test plan
All scenarios use WIDTH 11 and behavioural FloPoCo core models; encodings are 1.0 = 0x270, 2.0 = 0x280, 3.0 = 0x288, 8.0 = 0x2A0.
- N_TERMS 2, MUL_LAT = ADD_LAT = 1, init 0x270, pairs (0x280, 0x288), (0x270, 0x270), in_valid always high → out_valid high exactly 7 cycles after start, out_r = 0x2A0.
- MUL_LAT 3, ADD_LAT 2, N_TERMS 1, init 0x000, pair (0x280, 0x280) → fmul_ce high for exactly 3 cycles, fadd_ce high for 2, out_r = 0x290 (4.0), latency 7.
- Drop in_valid for 5 cycles between terms → both ce lines 0 throughout the gap, final result unchanged, latency +5.
- Hold out_ready = 0 for 4 cycles in DONE → out_valid and out_r stable, in_ready = 0, start pulses ignored, then IDLE after the handshake.
- Assert rst in the 2nd MUL cycle → all outputs 0 the same instant; a new start afterwards produces the correct fresh result (no stale acc).
- Pulse start while busy → no effect on the term count or the result.

Source files
------------

// File: rtl/fmac_pkg.sv
// fmac_pkg: shared types and FloPoCo encoding helpers
// for the multiply-accumulate sequencer.
package fmac_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MUL,
    S_ADD,
    S_DONE
  } fmac_state_t;

  // FloPoCo word: {exc[1:0], sign, exponent[wE], fraction[wF]}
  localparam int EXC_W  = 2;
  localparam int SIGN_W = 1;
  localparam int WE_DEF = 4;
  localparam int WF_DEF = 4;

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  function automatic int fp_width(input int we, input int wf);
    return EXC_W + SIGN_W + we + wf;
  endfunction

  function automatic logic [63:0] fp_zero(input int we, input int wf);
    return 64'(EXC_ZERO) << (SIGN_W + we + wf);
  endfunction

  function automatic logic [63:0] fp_one(input int we, input int wf);
    logic [63:0] bias;
    bias = (64'd1 << (we - 1)) - 64'd1;
    return (64'(EXC_NORM) << (SIGN_W + we + wf)) | (bias << wf);
  endfunction

  localparam logic [63:0] FP_ZERO = fp_zero(WE_DEF, WF_DEF);
  localparam logic [63:0] FP_ONE  = fp_one(WE_DEF, WF_DEF);

endpackage

// File: rtl/fmac_seq.sv
// fmac_seq: sequences r = init + sum(a_i*b_i) over a stream,
// time-sharing external ce-gated FloPoCo multiplier and adder.
module fmac_seq
  import fmac_pkg::*;
#(
  parameter int WIDTH   = 11,
  parameter int N_TERMS = 4,
  parameter int MUL_LAT = 1,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] init_val,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic [WIDTH-1:0] fmul_x,
  output logic [WIDTH-1:0] fmul_y,
  output logic             fmul_ce,
  input  logic [WIDTH-1:0] fmul_r,
  output logic [WIDTH-1:0] fadd_x,
  output logic [WIDTH-1:0] fadd_y,
  output logic             fadd_ce,
  input  logic [WIDTH-1:0] fadd_r
);

  localparam int TW = $clog2(N_TERMS + 1);
  localparam int MAX_LAT =
    (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int LW = $clog2(MAX_LAT + 1);

  localparam logic [TW-1:0] LAST_TERM = TW'(N_TERMS - 1);
  localparam logic [LW-1:0] MUL_CNT = LW'(MUL_LAT);
  localparam logic [LW-1:0] ADD_CNT = LW'(ADD_LAT);
  localparam logic [LW-1:0] LAT_ONE = LW'(1);
  localparam logic [WIDTH-1:0] ZERO_W = WIDTH'(FP_ZERO);

  fmac_state_t      state;
  logic [WIDTH-1:0] acc;
  logic [TW-1:0]    term;
  logic [LW-1:0]    lat;

  logic lat_done;
  logic last_term;
  logic in_fire;
  logic out_fire;

  // Core result is sampled on the edge ending the last ce-high cycle.
  assign lat_done  = (lat == LAT_ONE);
  assign last_term = (term == LAST_TERM);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= ZERO_W;
      term      <= '0;
      lat       <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= ZERO_W;
      fmul_x    <= ZERO_W;
      fmul_y    <= ZERO_W;
      fmul_ce   <= 1'b0;
      fadd_x    <= ZERO_W;
      fadd_y    <= ZERO_W;
      fadd_ce   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc      <= init_val;
            term     <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (in_fire) begin
            fmul_x   <= in_a;
            fmul_y   <= in_b;
            fmul_ce  <= 1'b1;
            lat      <= MUL_CNT;
            in_ready <= 1'b0;
            state    <= S_MUL;
          end
        end
        S_MUL: begin
          if (lat_done) begin
            fmul_ce <= 1'b0;
            fadd_x  <= acc;
            fadd_y  <= fmul_r;
            fadd_ce <= 1'b1;
            lat     <= ADD_CNT;
            state   <= S_ADD;
          end else begin
            lat <= lat - LAT_ONE;
          end
        end
        S_ADD: begin
          if (lat_done) begin
            acc     <= fadd_r;
            fadd_ce <= 1'b0;
            term    <= term + TW'(1);
            if (last_term) begin
              out_r     <= fadd_r;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              in_ready <= 1'b1;
              state    <= S_FETCH;
            end
          end else begin
            lat <= lat - LAT_ONE;
          end
        end
        S_DONE: begin
          if (out_fire) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          busy      <= 1'b0;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          fmul_ce   <= 1'b0;
          fadd_ce   <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
